// File: rtl/dmem_pkg.sv
// dmem_pkg: shared FSM states, access-size encodings and byte-lane enable helper for dmem_responder
package dmem_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off);
    return size == SZ_BYTE ? 4'b0001 << off : size == SZ_HALF ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  endfunction
endpackage

// File: rtl/dmem_array.sv
// dmem_array: single-port synchronous RAM with byte write enables; read register updates only on non-write accesses
module dmem_array #(
  parameter int DEPTH_WORDS = 256
) (
  input  logic                           clk,
  input  logic                           en_i,
  input  logic [3:0]                     we_i,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr_i,
  input  logic [31:0]                    wdata_i,
  output logic [31:0]                    rdata_o
);
  logic [31:0] mem [DEPTH_WORDS];
  always_ff @(posedge clk)
    if (en_i) begin
      for (int b = 0; b < 4; b++)
        if (we_i[b]) mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      if (we_i == 4'h0) rdata_o <= mem[addr_i];
    end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: MEM-stage data-memory responder with fixed wait states, stall and misalignment reporting.
// Define DMEM_BYTE_EN to honour req_size (byte/half lanes); otherwise every access is a full word.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  output logic        resp_valid,
  output logic [31:0] rdata,
  output logic        err,
  output logic        stall
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = WAIT_CYCLES > 0 ? $clog2(WAIT_CYCLES + 1) : 1;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic write_q, write_c, idle, go, mis, rd_ok_q, err_q, unused_addr;
  logic [AW+1:0] addr_q, addr_c;
  logic [31:0] wdata_q, wdata_c, wd_c, arr_rdata, rd_lane;
  logic [3:0] be_c;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    go = 1'b0;
    unique case (state_q)
      IDLE: if (req_valid) begin
        cnt_d = CW'(WAIT_CYCLES);
        go = WAIT_CYCLES == 0;
        state_d = go ? RESP : BUSY;
      end
      BUSY: begin
        cnt_d = cnt_q - CW'(1);
        go = req_valid && cnt_d == '0;
        state_d = !req_valid ? IDLE : go ? RESP : BUSY;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      rd_ok_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      if (go) begin
        err_q <= mis;
        rd_ok_q <= !mis && (!write_c || rd_ok_q);
      end
    end
  always_ff @(posedge clk)
    if (idle && req_valid) begin
      write_q <= req_write;
      addr_q <= req_addr[AW+1:0];
      wdata_q <= req_wdata;
    end
  // with zero wait states the access fires on the accept edge, so bypass the latches
  assign idle = state_q == IDLE;
  assign write_c = idle ? req_write : write_q;
  assign addr_c = idle ? req_addr[AW+1:0] : addr_q;
  assign wdata_c = idle ? req_wdata : wdata_q;
  assign unused_addr = ^req_addr[31:AW+2];
`ifdef DMEM_BYTE_EN
  logic [1:0] size_q, size_c, ld_off_q, ld_size_q;
  always_ff @(posedge clk) begin
    if (idle && req_valid) size_q <= req_size;
    if (go && !write_c && !mis) begin
      ld_off_q <= addr_c[1:0];
      ld_size_q <= size_c;
    end
  end
  assign size_c = idle ? req_size : size_q;
  assign mis = size_c == SZ_HALF ? addr_c[0] : size_c != SZ_BYTE && |addr_c[1:0];
  assign be_c = lane_be(size_c, addr_c[1:0]);
  assign wd_c = size_c == SZ_BYTE ? {4{wdata_c[7:0]}} : size_c == SZ_HALF ? {2{wdata_c[15:0]}} : wdata_c;
  assign rd_lane = ld_size_q == SZ_BYTE ? {24'b0, arr_rdata[{ld_off_q, 3'b0} +: 8]} :
                   ld_size_q == SZ_HALF ? {16'b0, arr_rdata[{ld_off_q[1], 4'b0} +: 16]} : arr_rdata;
`else
  logic unused_size;
  assign unused_size = ^req_size;
  assign mis = |addr_c[1:0];
  assign be_c = 4'hF;
  assign wd_c = wdata_c;
  assign rd_lane = arr_rdata;
`endif
  dmem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clk     (clk),
    .en_i    (go && !mis),
    .we_i    (write_c ? be_c : 4'h0),
    .addr_i  (addr_c[AW+1:2]),
    .wdata_i (wd_c),
    .rdata_o (arr_rdata)
  );
  assign resp_valid = state_q == RESP;
  assign rdata = rd_ok_q ? rd_lane : '0;
  assign err = err_q;
  assign stall = req_valid & ~resp_valid;
endmodule
